// File: rtl/inport_fifo.sv
// Input-port buffer feeding the datapath inportInput.
// The device pushes through a valid/ready handshake. Each rising edge of
// INPORTout advances the head word. Sticky ovf/unf flags are kept for polling.
module inport_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] dev_data,
  input  logic             dev_valid,
  output logic             dev_ready,
  input  logic             INPORTout,
  output logic [WIDTH-1:0] inport_data,
  output logic             inport_valid,
  output logic [AW:0]      count,
  output logic             ovf,
  output logic             unf,
  input  logic             clr_flags
);

  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cntQ;
  logic             inpQ;
  logic             ovfQ;
  logic             unfQ;

  logic full;
  logic empty;
  logic push;
  logic popReq;
  logic pop;

  // Handshake and pop decode from registered state only
  always_comb begin
    full   = (cntQ == FullCnt);
    empty  = (cntQ == '0);
    push   = dev_valid && !full;
    popReq = INPORTout && !inpQ;
    pop    = popReq && !empty;
  end

  // Storage write; contents are not reset because they are invisible while empty
  always_ff @(posedge Clock) begin
    if (push && Reset) mem[wp] <= dev_data;
  end

  // Pointers, occupancy, strobe edge detect and sticky flags
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wp   <= '0;
      rp   <= '0;
      cntQ <= '0;
      inpQ <= 1'b0;
      ovfQ <= 1'b0;
      unfQ <= 1'b0;
    end else begin
      inpQ <= INPORTout;
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop)      cntQ <= cntQ + (AW+1)'(1);
      else if (pop && !push) cntQ <= cntQ - (AW+1)'(1);
      // Clearing wins over a same-cycle set so software never misses the clear
      if (clr_flags) begin
        ovfQ <= 1'b0;
        unfQ <= 1'b0;
      end else begin
        if (dev_valid && full) ovfQ <= 1'b1;
        if (popReq && empty)   unfQ <= 1'b1;
      end
    end
  end

  // Output drive; the head reads as zero when nothing is buffered
  always_comb begin
    dev_ready    = !full;
    inport_valid = !empty;
    inport_data  = empty ? '0 : mem[rp];
    count        = cntQ;
    ovf          = ovfQ;
    unf          = unfQ;
  end

endmodule

// File: doc/inport_fifo.md
# inport_fifo

Input-port buffer placed directly upstream of the processor datapath's `inportInput`. It captures words from an external device through a valid/ready handshake and stores them in a circular FIFO. It presents the oldest word to the datapath's free-running INPORT register, and advances to the next word once per `INPORTout` assertion issued by the control unit during an `in` instruction. Sticky flags record overflow (write while full) and underflow (read while empty) for software polling.

## Interface
Parameters:
- `WIDTH`, 32, data word width; matches the datapath bus.
- `DEPTH`, 8, number of FIFO entries; must be a power of two, 2 or more.
- `AW`, log2(`DEPTH`) = 3, pointer width.

Ports:
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `dev_data`  in  `WIDTH`  word from the external device.
- `dev_valid`  in  1  device offers `dev_data` this cycle.
- `dev_ready`  out  1  FIFO can accept a word; equals !full.
- `INPORTout`  in  1  control-unit strobe for an `in` instruction; may be held for several cycles.
- `inport_data`  out  `WIDTH`  head word, or 0 when empty; drives datapath `inportInput`.
- `inport_valid`  out  1  FIFO non-empty.
- `count`  out  `AW`+1  occupancy, 0 to `DEPTH`.
- `ovf`  out  1  sticky overflow flag.
- `unf`  out  1  sticky underflow flag.
- `clr_flags`  in  1  synchronous clear of `ovf` and `unf`.

## Operation
- Storage is a `DEPTH` x `WIDTH` array with write pointer `wp`, read pointer `rp` (each `AW` bits, wrapping modulo `DEPTH`) and an `AW`+1 bit occupancy counter.
- Full means `count` == `DEPTH`; empty means `count` == 0.
- **Push:** `dev_valid` && `dev_ready` at an edge. The array stores `dev_data` at `wp`, then `wp` increments.
- **Pop request:** rising edge of `INPORTout`, i.e. `INPORTout` && !`inp_q`, where `inp_q` is a registered copy of `INPORTout`. Holding `INPORTout` for N cycles produces exactly one pop.
- **Pop:** a pop request while non-empty increments `rp`.
- **Underflow:** a pop request while empty leaves `rp` unchanged and sets `unf`.
- **Overflow:** `dev_valid` while full sets `ovf`; the word is dropped and no state changes.
- `inport_data` is combinational `mem[rp]` when non-empty and 0 when empty. It stays stable between pops.
- **Count update:** +1 on push only; -1 on pop only; unchanged on simultaneous push and pop, or on neither.
- **Simultaneous push and pop, full:** `dev_ready` is 0, so only the pop occurs, `count` becomes `DEPTH`-1, and `ovf` is set if `dev_valid` was asserted.
- **Simultaneous push and pop, empty:** the push is accepted, the pop is an underflow, `count` becomes 1, and `unf` is set.
- **Flags:** `clr_flags` has priority over setting in the same cycle, so the flags read 0 after that edge.
- **Reset (`Reset` low, asynchronous):**
  - `wp`, `rp`, `count`, `inp_q`, `ovf` and `unf` all go to 0.
  - Outputs therefore go to `dev_ready`=1, `inport_valid`=0, `inport_data`=0.
  - Array contents are not reset; they are unobservable while empty.
  - Reset mid-transfer discards all buffered words. A push or pop in the same cycle as reset assertion has no effect.

## Timing
- **Push latency:** a word accepted at edge k appears on `inport_data` after edge k if the FIFO was empty. The datapath INPORT register captures it at edge k+1.
- **Pop latency:** `INPORTout` rising before edge k advances `inport_data` after edge k. The control unit must therefore drive the bus from INPORT in the same T-state as the `INPORTout` strobe. INPORT holds the pre-pop word through edge k, so the word read is the pre-pop head.
- `dev_ready`, `inport_valid` and `count` are registered-state derived and change only after edges or on reset.
- Maximum throughput is one push per cycle, plus one pop per two cycles (edge-detect limit).

## Test plan
- **Reset/idle:** hold `Reset` low, then release. Require `dev_ready`=1, `inport_valid`=0, `count`=0, `inport_data`=0, `ovf`=`unf`=0.
- **Fill and drain in order:** push 0x11 to 0x88 on consecutive cycles. Require `count`=8 and `dev_ready`=0. Then pulse `INPORTout` 8 times; `inport_data` must read 0x11, 0x22 … 0x88, then 0 with `inport_valid`=0.
- **Overflow:** while full, assert `dev_valid` with 0xDEAD. Require `ovf`=1, `count`=8 and head unchanged. Pulse `clr_flags` and require `ovf`=0.
- **Held strobe:** with 3 entries queued, hold `INPORTout` for 5 cycles. Require exactly one pop and `count`=2.
- **Simultaneous events:**
  - Empty plus push 0x5A plus pop request: require `count`=1, `inport_data`=0x5A, `unf`=1.
  - `count`=4 plus push plus pop: require `count`=4 and the head to advance.
- **Wrap-around and mid-operation reset:** do 12 push/pop pairs so the pointers wrap; data order must be preserved. Then assert `Reset` with `count`=3 mid-cycle; require an immediate `count`=0, `inport_data`=0, `dev_ready`=1.
